// File: rtl/text2_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz text-mode generator.
package text2_pkg;

    // Horizontal timing, in pixel ticks.
    localparam logic [9:0] H_VIS        = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_VIS + H_FP + H_SYNC;

    // Vertical timing, in lines.
    localparam logic [9:0] V_VIS        = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_VIS + V_FP + V_SYNC;

    // {R,G,B}, R in the MSB.
    typedef logic [2:0] rgb_t;

endpackage

// File: rtl/text2_font_rom.sv
// 16-glyph 8x8 hex-digit font ('0'..'9','A'..'F'), registered output.
// Address is {code[3:0], glyph_row[2:0]}; bit 7 of the data is the leftmost pixel.
module text2_font_rom (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [6:0] addr_i,
    output logic [7:0] data_o
);

    logic [63:0] glyph;
    logic [7:0]  row_d;
    logic [7:0]  data_q;

    // Glyph lookup; row 0 sits in the top byte.
    always_comb begin
        glyph = 64'h0;
        unique case (addr_i[6:3])
            4'h0: glyph = 64'h3C666E7666663C00;
            4'h1: glyph = 64'h183818181818_7E00;
            4'h2: glyph = 64'h3C66060C30607E00;
            4'h3: glyph = 64'h3C66061C06663C00;
            4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5: glyph = 64'h7E607C0606663C00;
            4'h6: glyph = 64'h3C607C6666663C00;
            4'h7: glyph = 64'h7E060C1830303000;
            4'h8: glyph = 64'h3C66663C66663C00;
            4'h9: glyph = 64'h3C66663E060C3800;
            4'hA: glyph = 64'h183C66667E666600;
            4'hB: glyph = 64'h7C66667C66667C00;
            4'hC: glyph = 64'h3C66606060663C00;
            4'hD: glyph = 64'h786C6666666C7800;
            4'hE: glyph = 64'h7E60607C60607E00;
            4'hF: glyph = 64'h7E60607C60606000;
            default: glyph = 64'h0;
        endcase
        row_d = glyph[{3'd7 - addr_i[2:0], 3'b000} +: 8];
    end

    // Output register, advanced only on pixel ticks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= 8'h00;
        end else if (en_i) begin
            data_q <= row_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/text2_export_vga.sv
// VGA text-mode generator: 640x480@60 Hz from a 50 MHz clock, 80x30 cells of 8x16
// pixels showing (col+row) mod 16 as hex digits, per-row foreground on black.
// Two-tick pipeline from counters to pins: tick 1 registers colour, sync, active,
// pixel column and the font row (ROM output register); tick 2 registers pins.
// Optional feature macro: CURSOR_EN (inverse-video blinking cursor at cell 0,0).
module text2_export_vga
    import text2_pkg::*;
(
    input  logic RESET,
    input  logic CLOCK_50,
    output logic VGA_RED,
    output logic VGA_GREEN,
    output logic VGA_BLUE,
    output logic VGA_HSYNC,
    output logic VGA_VSYNC
);

    logic       pix_en_q;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       h_last, v_last;

    // Stage 1 next-state and registers.
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic [4:0] row;
    logic [4:0] row_mod7;
    rgb_t       fg_d, fg_q;
    logic [2:0] bit_sel_q;
    logic       active_d, active_q;
    logic       hs_d, hs1_q;
    logic       vs_d, vs1_q;
    logic       inv_d, inv_q;

    // Output stage.
    logic       pix;
    rgb_t       rgb_d, rgb_q;
    logic       hsync_q, vsync_q;

    // 25 MHz tick: pix_en alternates every system clock.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
        end
    end

    assign h_last = (hcount_q == H_TOTAL - 10'd1);
    assign v_last = (vcount_q == V_TOTAL - 10'd1);

    // Raster counter next-state.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (h_last) begin
                hcount_d = 10'd0;
                vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Raster counter registers.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

`ifdef CURSOR_EN
    logic [5:0] frame_q;

    // Frame counter for the cursor blink; bit 5 flips every 32 frames.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            frame_q <= 6'd0;
        end else if (pix_en_q && h_last && v_last) begin
            frame_q <= frame_q + 6'd1;
        end
    end

    // Cursor cell is inverted while the blink phase bit is low.
    always_comb begin
        inv_d = (hcount_q[9:3] == 7'd0) && (vcount_q[9:4] == 6'd0) && !frame_q[5];
    end
`else
    // No cursor: nothing is ever inverted.
    always_comb begin
        inv_d = 1'b0;
    end
`endif

    // Text mapping, colour, sync and blanking decode from the current counters.
    always_comb begin
        row      = vcount_q[8:4];
        row_mod7 = row % 5'd7;
        fg_d     = row_mod7[2:0] + 3'd1;
        // 4-bit sum of col and row low nibbles is (col+row) mod 16.
        rom_addr = {hcount_q[6:3] + vcount_q[7:4], vcount_q[3:1]};
        active_d = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        hs_d     = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
        vs_d     = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
    end

    text2_font_rom u_font_rom (
        .clk_i  (CLOCK_50),
        .rst_ni (RESET),
        .en_i   (pix_en_q),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Stage 1: side-band values that travel alongside the font ROM read.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            fg_q      <= '0;
            bit_sel_q <= 3'd0;
            active_q  <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            inv_q     <= 1'b0;
        end else if (pix_en_q) begin
            fg_q      <= fg_d;
            bit_sel_q <= hcount_q[2:0];
            active_q  <= active_d;
            hs1_q     <= hs_d;
            vs1_q     <= vs_d;
            inv_q     <= inv_d;
        end
    end

    // Pixel select; blanking forces black regardless of glyph or cursor.
    always_comb begin
        pix   = rom_data[3'd7 - bit_sel_q] ^ inv_q;
        rgb_d = (active_q && pix) ? fg_q : '0;
    end

    // Stage 2: pin registers, RGB and syncs aligned.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (pix_en_q) begin
            rgb_q   <= rgb_d;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
        end
    end

    assign VGA_RED   = rgb_q[2];
    assign VGA_GREEN = rgb_q[1];
    assign VGA_BLUE  = rgb_q[0];
    assign VGA_HSYNC = hsync_q;
    assign VGA_VSYNC = vsync_q;

endmodule

// File: tb/tb_text2_export_vga.sv
// Bench for text2_export_vga: reset behaviour, pixel/sync scoreboard against an
// independent raster model, horizontal sync timing, and a mid-line reset.
module tb_text2_export_vga;

    logic RESET;
    logic CLOCK_50;
    logic VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         h;
        int         v;
        logic [4:0] pins;
    } exp_t;

    exp_t sb[$];

    text2_export_vga dut (
        .RESET     (RESET),
        .CLOCK_50  (CLOCK_50),
        .VGA_RED   (VGA_RED),
        .VGA_GREEN (VGA_GREEN),
        .VGA_BLUE  (VGA_BLUE),
        .VGA_HSYNC (VGA_HSYNC),
        .VGA_VSYNC (VGA_VSYNC)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] font_glyph(input int code);
        case (code)
            0:  return 64'h3C666E7666663C00;
            1:  return 64'h1838181818187E00;
            2:  return 64'h3C66060C30607E00;
            3:  return 64'h3C66061C06663C00;
            4:  return 64'h0C1C3C6C7E0C0C00;
            5:  return 64'h7E607C0606663C00;
            6:  return 64'h3C607C6666663C00;
            7:  return 64'h7E060C1830303000;
            8:  return 64'h3C66663C66663C00;
            9:  return 64'h3C66663E060C3800;
            10: return 64'h183C66667E666600;
            11: return 64'h7C66667C66667C00;
            12: return 64'h3C66606060663C00;
            13: return 64'h786C6666666C7800;
            14: return 64'h7E60607C60607E00;
            default: return 64'h7E60607C60606000;
        endcase
    endfunction

    // Expected {R,G,B,HSYNC,VSYNC} for raster position (h,v); bench stays in frame 0.
    function automatic logic [4:0] model(input int h, input int v);
        logic [63:0] g;
        logic        hs, vs, act, bitv;
        logic [2:0]  rgb;
        int          col, row, code, grow;
        hs   = !(h >= 656 && h <= 751);
        vs   = !(v >= 490 && v <= 491);
        act  = (h < 640) && (v < 480);
        col  = h / 8;
        row  = v / 16;
        code = (col + row) % 16;
        grow = (v % 16) / 2;
        g    = font_glyph(code);
        bitv = g[63 - grow * 8 - (h % 8)];
`ifdef CURSOR_EN
        if (col == 0 && row == 0) bitv = !bitv;
`endif
        rgb  = (act && bitv) ? 3'((row % 7) + 1) : 3'b000;
        return {rgb, hs, vs};
    endfunction

    // Runs the raster for a number of system clocks starting just after reset release.
    task automatic run_scan(input int cycles);
        int         h = 0;
        int         v = 0;
        bit         en = 1'b0;
        bit         ticked;
        logic       prev_hs = 1'b1;
        int         last_fall = -1;
        exp_t       e;
        logic [4:0] pins;
        logic [2:0] cell00_exp;
`ifdef CURSOR_EN
        cell00_exp = 3'b000;
`else
        cell00_exp = 3'b001;
`endif
        sb.delete();
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLOCK_50);
            ticked = en;
            if (en) begin
                e.h = h;
                e.v = v;
                e.pins = model(h, v);
                sb.push_back(e);
                h++;
                if (h == 800) begin
                    h = 0;
                    v++;
                    if (v == 525) v = 0;
                end
            end
            en = !en;
            #1;
            pins = {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC};
            if (ticked && sb.size() > 1) begin
                e = sb.pop_front();
                check_eq($sformatf("pins h=%0d v=%0d", e.h, e.v), {3'b0, pins}, {3'b0, e.pins});
                if (e.v == 0 && e.h == 11) check_eq("cell1_0_on", {5'b0, pins[4:2]}, 8'd1);
                if (e.v == 0 && e.h == 8) check_eq("cell1_0_off", {5'b0, pins[4:2]}, 8'd0);
                if (e.v == 16 && e.h == 3) check_eq("cell0_1_on", {5'b0, pins[4:2]}, 8'd2);
                if (e.v == 0 && e.h == 121) check_eq("cell15_0_on", {5'b0, pins[4:2]}, 8'd1);
                if (e.v == 0 && e.h == 120) check_eq("cell15_0_off", {5'b0, pins[4:2]}, 8'd0);
                if (e.v == 0 && e.h == 2) check_eq("cell0_0", {5'b0, pins[4:2]}, {5'b0, cell00_exp});
            end
            if (prev_hs === 1'b1 && VGA_HSYNC === 1'b0) begin
                if (last_fall >= 0) check_eq("hsync_period_ok", 8'(i - last_fall == 1600), 8'd1);
                last_fall = i;
            end else if (prev_hs === 1'b0 && VGA_HSYNC === 1'b1 && last_fall >= 0) begin
                check_eq("hsync_low_ok", 8'(i - last_fall == 192), 8'd1);
            end
            prev_hs = VGA_HSYNC;
        end
    endtask

    initial begin
        RESET = 1'b1;
        #40 RESET = 1'b0;
        #20;
        check_eq("reset_rgb", {5'b0, VGA_RED, VGA_GREEN, VGA_BLUE}, 8'd0);
        check_eq("reset_hsync", {7'b0, VGA_HSYNC}, 8'd1);
        check_eq("reset_vsync", {7'b0, VGA_VSYNC}, 8'd1);
        #20 RESET = 1'b1;

        // Short run into the first line's sync pulse, then reset mid-line.
        run_scan(1400);
        check_eq("pre_reset_hsync_low", {7'b0, VGA_HSYNC}, 8'd0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        #1;
        check_eq("midreset_rgb", {5'b0, VGA_RED, VGA_GREEN, VGA_BLUE}, 8'd0);
        check_eq("midreset_hsync", {7'b0, VGA_HSYNC}, 8'd1);
        check_eq("midreset_vsync", {7'b0, VGA_VSYNC}, 8'd1);
        @(negedge CLOCK_50);
        RESET = 1'b1;

        // Scan restarts at (0,0): 34 lines covering text rows 0..2.
        run_scan(34 * 1600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
